booth_mult_seq: RTL and testbench
=================================

# booth_mult_seq

Parametrised sequential radix-2 Booth multiplier for WIDTH-bit operands, in signed or unsigned mode selected per operation. It produces a 2·WIDTH-bit product after a fixed WIDTH+1 iteration cycles, using a start/busy/done handshake and a held product register. It succeeds the fixed 4-bit Booth multiplier in the arithmetic library and serves datapaths that need a small-area, multi-cycle multiply at arbitrary width.

## Interface
- WIDTH, 8, operand width in bits; legal range ≥ 2.
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  requests an operation; sampled only in IDLE.
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned; captured with start.
- mc  in  WIDTH  multiplicand; captured with start.
- mp  in  WIDTH  multiplier; captured with start.
- prod  out  2·WIDTH  result register; holds its value until the next completion.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse; marks the cycle in which prod first shows a new result.

## Operation
- States are IDLE and RUN.
- **Reset** (asynchronous, any state, including mid-operation):
  - state = IDLE; busy = 0, done = 0, prod = 0.
  - Internal A, Q, Q_1, M and the counter are cleared; any in-flight operation is discarded.
- **IDLE with start = 1**, on the clock edge:
  - Load M, Q and A, each WIDTH+1 bits wide.
  - M = mc extended by one bit: sign bit if is_signed, else 0.
  - Q = mp extended the same way.
  - A = 0, Q_1 = 0, count = 0.
  - Go to RUN; busy = 1.
- **IDLE with start = 0**: no state change. done is 0 except in its pulse cycle.
- **RUN, each edge, one iteration** (arithmetic is modulo 2^(WIDTH+1)):
  - {Q[0],Q_1} = 01: A' = A + M.
  - {Q[0],Q_1} = 10: A' = A + ~M + 1.
  - Otherwise: A' = A.
  - Then arithmetic-shift right {A',Q,Q_1} by one bit, replicating A'[WIDTH].
  - count increments.
- **RUN completion**: on the edge that performs iteration WIDTH+1 (count = WIDTH before that edge):
  - prod = low 2·WIDTH bits of the shifted {A,Q}.
  - done = 1, busy = 0; state goes to IDLE.
- The extra operand bit makes unsigned mode exact. The true product always fits in 2·WIDTH bits, so truncation loses nothing in either mode.
- start, mc, mp and is_signed are ignored while in RUN; there is no abort other than reset.
- done drops on the following edge unless a new operation completes there, which cannot happen.

## Timing
- Latency: with start accepted at edge E, done = 1 and prod valid after edge E+WIDTH+1.
- busy is high from after edge E through edge E+WIDTH+1, i.e. WIDTH+1 cycles.
- Throughput: one result per WIDTH+2 cycles. start held high in the done cycle is accepted at the next edge, giving back-to-back operations.
- Outputs are registered, with no combinational path from inputs to outputs.
- counter width = $clog2(WIDTH+2).

## Structure
- Package booth_pkg holds:
  - state encodings (ST_IDLE, ST_RUN);
  - the Booth recode constants (OP_ADD = 2'b01, OP_SUB = 2'b10).
- Sub-module booth_addsub (parameter W = WIDTH+1):
  - computes a + (sub ? ~b : b) + sub;
  - one instance, with the add/sub select driven from {Q[0],Q_1}.
- All operand and product widths derive from WIDTH; there are no hard-coded widths.

## Test plan
- WIDTH=8, signed, mc=-128, mp=-128 -> prod = 16'h4000 (16384); done after 9 busy cycles.
- WIDTH=8, unsigned, mc=255, mp=255 -> prod = 16'hFE01 (65025).
- WIDTH=8, signed, mc=7, mp=-3 -> prod = 16'hFFEB; then unsigned 7×253 -> 16'h06EB.
- Pulse start with mc=5, mp=6 in RUN during an operation 3×4 -> second start ignored; prod = 12; exactly one done pulse.
- Assert rst_n = 0 at the 4th RUN cycle of 100×100 (unsigned) -> busy, done and prod = 0 immediately; after release, IDLE with no done.
- WIDTH=16, start held high continuously with random operands against a reference model -> results correct, done every 18 cycles. Repeat at WIDTH=2 with an exhaustive sweep in both modes.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier.
package booth_pkg;

    // Controller states.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Booth recode of {Q[0], Q_1}: 01 adds the multiplicand, 10 subtracts it.
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;

endpackage

// File: rtl/booth_addsub.sv
// W-bit adder/subtractor: sum = a + (sub ? ~b : b) + sub, modulo 2^W.
module booth_addsub #(
    parameter int W = 9
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         sub_i,
    output logic [W-1:0] sum_o
);

    // Subtraction reuses the adder: invert b and inject the +1 as carry-in.
    assign sum_o = a_i + (sub_i ? ~b_i : b_i) + {{(W-1){1'b0}}, sub_i};

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, signed or unsigned per operation.
// Operands are widened by one bit so unsigned inputs stay exact; WIDTH+1
// iterations yield a product that always fits in 2*WIDTH bits.
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     mc,
    input  logic [WIDTH-1:0]     mp,
    output logic [2*WIDTH-1:0]   prod,
    output logic                 busy,
    output logic                 done
);

    localparam int                W        = WIDTH + 1;
    localparam int                CNT_W    = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH);

    state_e               state_q;
    logic [W-1:0]         a_q;
    logic [W-1:0]         q_q;
    logic [W-1:0]         m_q;
    logic                 q1_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [2*WIDTH-1:0]   prod_q;
    logic                 busy_q;
    logic                 done_q;

    logic [1:0]           recode;
    logic [W-1:0]         sum;
    logic [W-1:0]         a_acc;
    logic [W-1:0]         a_d;
    logic [W-1:0]         q_d;
    logic                 q1_d;
    logic [2*WIDTH-1:0]   prod_d;

    assign recode = {q_q[0], q1_q};

    booth_addsub #(
        .W (W)
    ) u_addsub (
        .a_i   (a_q),
        .b_i   (m_q),
        .sub_i (recode == OP_SUB),
        .sum_o (sum)
    );

    // Accumulator update for this iteration: add/subtract M or keep A.
    always_comb begin
        // NOTE: assign a default first so every path drives a_acc and no latch is inferred.
        a_acc = a_q;
        if (recode == OP_ADD || recode == OP_SUB) begin
            a_acc = sum;
        end
    end

    // Arithmetic shift right of {A', Q, Q_1} by one, replicating A'[W-1].
    assign a_d    = {a_acc[W-1], a_acc[W-1:1]};
    assign q_d    = {a_acc[0], q_q[W-1:1]};
    assign q1_d   = q_q[0];
    assign prod_d = {a_d[WIDTH-2:0], q_d};

    // Controller and datapath registers: load on start, iterate in RUN, publish on the last step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            prod_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        m_q     <= {is_signed & mc[WIDTH-1], mc};
                        q_q     <= {is_signed & mp[WIDTH-1], mp};
                        a_q     <= '0;
                        q1_q    <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_q   <= a_d;
                    q_q   <= q_d;
                    q1_q  <= q1_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        prod_q  <= prod_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign prod = prod_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq at WIDTH = 8, 16 and 2.
module tb_booth_mult_seq;

    int checks   = 0;
    int failures = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        start8, sgn8, busy8, done8;
    logic [7:0]  mc8, mp8;
    logic [15:0] prod8;

    logic        start16, sgn16, busy16, done16;
    logic [15:0] mc16, mp16;
    logic [31:0] prod16;

    logic        start2, sgn2, busy2, done2;
    logic [1:0]  mc2, mp2;
    logic [3:0]  prod2;

    logic [63:0] sb8[$];
    logic [63:0] sb16[$];
    logic [63:0] sb2[$];

    booth_mult_seq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .is_signed(sgn8),
        .mc(mc8), .mp(mp8), .prod(prod8), .busy(busy8), .done(done8)
    );

    booth_mult_seq #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .is_signed(sgn16),
        .mc(mc16), .mp(mp16), .prod(prod16), .busy(busy16), .done(done16)
    );

    booth_mult_seq #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .is_signed(sgn2),
        .mc(mc2), .mp(mp2), .prod(prod2), .busy(busy2), .done(done2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference product of two w-bit operands, truncated to 2w bits.
    function automatic logic [63:0] model(input int w, input bit sgn,
                                          input logic [31:0] a, input logic [31:0] b);
        longint x;
        longint y;
        longint p;
        x = longint'(a);
        y = longint'(b);
        if (sgn && a[w-1]) x = x - (longint'(1) << w);
        if (sgn && b[w-1]) y = y - (longint'(1) << w);
        p = x * y;
        return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    // One isolated WIDTH=8 operation with latency, pulse and hold checks.
    task automatic run8(input string tag, input bit sgn, input logic [7:0] a,
                        input logic [7:0] b, input logic [15:0] exp);
        int          bcnt;
        logic [63:0] e;
        @(negedge clk);
        sgn8 = sgn; mc8 = a; mp8 = b; start8 = 1'b1;
        sb8.push_back(64'(exp));
        @(negedge clk);
        start8 = 1'b0;
        bcnt = 0;
        while (busy8 && bcnt < 40) begin
            bcnt++;
            @(negedge clk);
        end
        check({tag, " busy_cycles"}, 64'(bcnt), 64'd9);
        check({tag, " done"}, 64'(done8), 64'd1);
        e = sb8.pop_front();
        check({tag, " prod"}, 64'(prod8), e);
        @(negedge clk);
        check({tag, " done_drop"}, 64'(done8), 64'd0);
        check({tag, " prod_hold"}, 64'(prod8), e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          dcnt;
        int          bseen;
        int          gap;
        logic [15:0] pcap;
        logic [63:0] e;

        rst_n = 1'b0;
        start8 = 1'b0; sgn8 = 1'b0; mc8 = '0; mp8 = '0;
        start16 = 1'b0; sgn16 = 1'b0; mc16 = '0; mp16 = '0;
        start2 = 1'b0; sgn2 = 1'b0; mc2 = '0; mp2 = '0;
        repeat (3) @(negedge clk);
        check("reset prod", 64'(prod8), 64'd0);
        check("reset busy", 64'(busy8), 64'd0);
        check("reset done", 64'(done8), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle no done", 64'(done8), 64'd0);

        run8("s_m128xm128", 1'b1, 8'h80, 8'h80, 16'h4000);
        run8("u_255x255",   1'b0, 8'hFF, 8'hFF, 16'hFE01);
        run8("s_7xm3",      1'b1, 8'h07, 8'hFD, 16'hFFEB);
        run8("u_7x253",     1'b0, 8'h07, 8'hFD, 16'h06EB);

        // Stray start during RUN must be ignored.
        @(negedge clk);
        sgn8 = 1'b0; mc8 = 8'd3; mp8 = 8'd4; start8 = 1'b1;
        sb8.push_back(64'd12);
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        mc8 = 8'd5; mp8 = 8'd6; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        dcnt = 0;
        pcap = '0;
        for (int i = 0; i < 30; i++) begin
            if (done8) begin
                dcnt++;
                pcap = prod8;
            end
            @(negedge clk);
        end
        check("ignore_start done_count", 64'(dcnt), 64'd1);
        e = sb8.pop_front();
        check("ignore_start prod", 64'(pcap), e);
        check("ignore_start busy", 64'(busy8), 64'd0);

        // Reset in the 4th RUN cycle discards the operation.
        @(negedge clk);
        sgn8 = 1'b0; mc8 = 8'd100; mp8 = 8'd100; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst busy_before", 64'(busy8), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrst busy", 64'(busy8), 64'd0);
        check("midrst done", 64'(done8), 64'd0);
        check("midrst prod", 64'(prod8), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        bseen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done8) dcnt++;
            if (busy8) bseen++;
        end
        check("midrst no_done", 64'(dcnt), 64'd0);
        check("midrst idle", 64'(bseen), 64'd0);
        check("midrst prod_after", 64'(prod8), 64'd0);

        run8("post_rst s_m5x9", 1'b1, 8'hFB, 8'h09, 16'hFFD3);

        // WIDTH=16 back-to-back with start held high and random operands.
        @(negedge clk);
        sgn16 = 1'($urandom); mc16 = 16'($urandom); mp16 = 16'($urandom);
        start16 = 1'b1;
        sb16.push_back(model(16, sgn16, 32'(mc16), 32'(mp16)));
        for (int k = 0; k < 20; k++) begin
            gap = 0;
            do begin
                @(negedge clk);
                gap++;
            end while (!done16 && gap < 60);
            check("w16 interval", 64'(gap), 64'd18);
            e = sb16.pop_front();
            check("w16 prod", 64'(prod16), e);
            if (k < 19) begin
                sgn16 = 1'($urandom); mc16 = 16'($urandom); mp16 = 16'($urandom);
                sb16.push_back(model(16, sgn16, 32'(mc16), 32'(mp16)));
            end else begin
                start16 = 1'b0;
            end
        end

        // WIDTH=2 exhaustive sweep in both modes, back-to-back.
        @(negedge clk);
        sgn2 = 1'b0; mc2 = 2'd0; mp2 = 2'd0;
        start2 = 1'b1;
        sb2.push_back(model(2, sgn2, 32'(mc2), 32'(mp2)));
        for (int k = 0; k < 32; k++) begin
            logic [4:0] nxt;
            gap = 0;
            do begin
                @(negedge clk);
                gap++;
            end while (!done2 && gap < 20);
            check("w2 interval", 64'(gap), 64'd4);
            e = sb2.pop_front();
            check("w2 prod", 64'(prod2), e);
            if (k < 31) begin
                nxt = 5'(k + 1);
                sgn2 = nxt[4]; mc2 = nxt[3:2]; mp2 = nxt[1:0];
                sb2.push_back(model(2, sgn2, 32'(mc2), 32'(mp2)));
            end else begin
                start2 = 1'b0;
            end
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
